// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA priority encoder / bus arbiter.
package dma_pkg;

  localparam int NUM_CH = 4;

  typedef logic [1:0] ch_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HLDA = 2'd1,
    GRANT     = 2'd2
  } state_t;

  // Scan requests starting at the highest-priority channel. In fixed mode
  // that is ch0; in rotating mode it is the channel after the last grant.
  function automatic ch_t pick_winner(input logic [NUM_CH-1:0] req,
                                      input logic rot,
                                      input ch_t last);
    ch_t  start_v;
    ch_t  idx_v;
    ch_t  win_v;
    logic found_v;
    start_v = rot ? ch_t'(last + 2'd1) : 2'd0;
    win_v   = 2'd0;
    found_v = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx_v = ch_t'(start_v + ch_t'(k));
      if (!found_v && req[idx_v]) begin
        win_v   = idx_v;
        found_v = 1'b1;
      end else begin
        found_v = found_v;
      end
    end
    return win_v;
  endfunction

  // One-hot acknowledge vector for a channel index.
  function automatic logic [NUM_CH-1:0] ch_onehot(input ch_t ch);
    logic [NUM_CH-1:0] v;
    v     = {NUM_CH{1'b0}};
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dma_priority_if.sv
// Request/acknowledge and command-register bundle between the arbiter and its
// surroundings (CPU hold handshake, peripherals, timing control).
interface dma_priority_if;
  import dma_pkg::*;

  logic [NUM_CH-1:0] dreq;
  logic              hlda;
  logic              hrq;
  logic [NUM_CH-1:0] dack;
  logic              dreq_sense_low;
  logic              dack_sense_high;
  logic              rot_pri;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] sw_req;
  logic              svc_done;
  logic              grant_valid;
  ch_t               grant_ch;
  logic              abort;

  // Arbiter side.
  modport slave (
    input  dreq, hlda, dreq_sense_low, dack_sense_high, rot_pri, mask, sw_req,
           svc_done,
    output hrq, dack, grant_valid, grant_ch, abort
  );

  // Environment side.
  modport master (
    output dreq, hlda, dreq_sense_low, dack_sense_high, rot_pri, mask, sw_req,
           svc_done,
    input  hrq, dack, grant_valid, grant_ch, abort
  );

endinterface

// File: rtl/dma_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
module dma_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;

  // Shift the input through two flops to settle metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= {WIDTH{1'b0}};
      q      <= {WIDTH{1'b0}};
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/dma_priority.sv
// DMA channel priority arbiter: synchronizes channel requests, runs the CPU
// hold handshake and grants the bus to one channel at a time, with fixed or
// rotating priority.
module dma_priority
  import dma_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  dma_priority_if.slave  bus
);

  logic [NUM_CH-1:0] dreq_pol_s;
  logic [NUM_CH-1:0] hw_req_s;
  logic [NUM_CH-1:0] eff_req_s;
  ch_t               winner_s;

  state_t            state_r;
  logic              hrq_r;
  logic              grant_valid_r;
  ch_t               grant_ch_r;
  logic              abort_r;
  logic [NUM_CH-1:0] active_r;
  ch_t               rot_ptr_r;

  // Normalise request polarity so that 1 always means "requesting".
  assign dreq_pol_s = bus.dreq ^ {NUM_CH{bus.dreq_sense_low}};

  dma_sync2 #(.WIDTH(NUM_CH)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (dreq_pol_s),
    .q   (hw_req_s)
  );

  // Effective requests: masked hardware requests plus unmaskable software ones.
  always_comb begin
    eff_req_s = (hw_req_s & ~bus.mask) | bus.sw_req;
  end

  // Current arbitration winner; only sampled when entering GRANT.
  always_comb begin
    winner_s = pick_winner(eff_req_s, bus.rot_pri, rot_ptr_r);
  end

  // Hold-request / grant state machine with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      hrq_r         <= 1'b0;
      grant_valid_r <= 1'b0;
      grant_ch_r    <= 2'd0;
      abort_r       <= 1'b0;
      active_r      <= {NUM_CH{1'b0}};
      rot_ptr_r     <= 2'd3;
    end else begin
      abort_r <= 1'b0;
      case (state_r)
        IDLE: begin
          grant_valid_r <= 1'b0;
          active_r      <= {NUM_CH{1'b0}};
          if (|eff_req_s) begin
            state_r <= WAIT_HLDA;
            hrq_r   <= 1'b1;
          end else begin
            state_r <= IDLE;
            hrq_r   <= 1'b0;
          end
        end
        WAIT_HLDA: begin
          if (bus.hlda && (|eff_req_s)) begin
            state_r       <= GRANT;
            grant_valid_r <= 1'b1;
            grant_ch_r    <= winner_s;
            active_r      <= ch_onehot(winner_s);
            rot_ptr_r     <= winner_s;
          end else if (!(|eff_req_s)) begin
            // Request withdrawn (with or without HLDA): back off, no grant.
            state_r <= IDLE;
            hrq_r   <= 1'b0;
          end else begin
            state_r <= WAIT_HLDA;
          end
        end
        GRANT: begin
          // svc_done wins over a simultaneous HLDA drop, so no abort then.
          if (bus.svc_done || !bus.hlda) begin
            state_r       <= IDLE;
            hrq_r         <= 1'b0;
            grant_valid_r <= 1'b0;
            active_r      <= {NUM_CH{1'b0}};
            abort_r       <= !bus.svc_done;
          end else begin
            state_r <= GRANT;
          end
        end
        default: begin
          state_r       <= IDLE;
          hrq_r         <= 1'b0;
          grant_valid_r <= 1'b0;
          active_r      <= {NUM_CH{1'b0}};
        end
      endcase
    end
  end

  assign bus.hrq         = hrq_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_ch    = grant_ch_r;
  assign bus.abort       = abort_r;
  // Acknowledge polarity follows the command register without a clock delay.
  assign bus.dack        = active_r ^ {NUM_CH{~bus.dack_sense_high}};

endmodule

// File: tb/tb_dma_priority.sv
// Self-checking bench for dma_priority: directed scenarios followed by
// randomized requests checked against a priority-order reference model.
module tb_dma_priority;
  import dma_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   last_m   = 3;

  dma_priority_if bus();

  dma_priority dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the channels in priority order and take the first request.
  function automatic int model_winner(input logic [3:0] req, input bit rot, input int last);
    int base;
    base = rot ? last + 1 : 0;
    for (int k = 0; k < 4; k++) begin
      if (req[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_hrq(input logic want, input int budget);
    int n;
    n = 0;
    while (bus.hrq !== want && n < budget) begin
      tick();
      n++;
    end
    check("hrq_wait", 32'(bus.hrq), 32'(want));
  endtask

  // One full service: HRQ, HLDA two cycles later, grant check, svc_done.
  task automatic serve(input int exp_ch, input bit drop, input bit both);
    logic [3:0] oh;
    wait_hrq(1'b1, 12);
    tick();
    tick();
    bus.hlda = 1'b1;
    tick();
    oh = 4'b0001 << exp_ch;
    check("grant_valid", 32'(bus.grant_valid), 32'(1'b1));
    check("grant_ch", 32'(bus.grant_ch), 32'(exp_ch));
    check("dack_grant", 32'(bus.dack), 32'(oh ^ {4{~bus.dack_sense_high}}));
    last_m = exp_ch;
    if (drop) begin
      bus.dreq   = {4{bus.dreq_sense_low}};
      bus.sw_req = 4'b0000;
      tick();
      tick();
      check("grant_hold", 32'(bus.grant_ch), 32'(exp_ch));
    end
    bus.svc_done = 1'b1;
    if (both) bus.hlda = 1'b0;
    tick();
    bus.svc_done = 1'b0;
    bus.hlda     = 1'b0;
    check("svc_hrq", 32'(bus.hrq), 32'(1'b0));
    check("svc_gv", 32'(bus.grant_valid), 32'(1'b0));
    check("svc_abort", 32'(bus.abort), 32'(1'b0));
    check("svc_dack", 32'(bus.dack), 32'({4{~bus.dack_sense_high}}));
  endtask

  initial begin
    logic [3:0] eff;
    bit         rot;

    rst                 = 1'b1;
    bus.dreq            = 4'b0000;
    bus.hlda            = 1'b0;
    bus.dreq_sense_low  = 1'b0;
    bus.dack_sense_high = 1'b0;
    bus.rot_pri         = 1'b0;
    bus.mask            = 4'b0000;
    bus.sw_req          = 4'b0000;
    bus.svc_done        = 1'b0;
    tick();
    tick();
    check("rst_hrq", 32'(bus.hrq), 32'(1'b0));
    check("rst_gv", 32'(bus.grant_valid), 32'(1'b0));
    check("rst_gch", 32'(bus.grant_ch), 32'(2'd0));
    check("rst_abort", 32'(bus.abort), 32'(1'b0));
    check("rst_dack", 32'(bus.dack), 32'(4'b1111));
    rst = 1'b0;
    tick();

    // Request latency: HRQ exactly on the third edge after DREQ rises.
    bus.dreq = 4'b0100;
    tick();
    check("lat_e1", 32'(bus.hrq), 32'(1'b0));
    tick();
    check("lat_e2", 32'(bus.hrq), 32'(1'b0));
    tick();
    check("lat_e3", 32'(bus.hrq), 32'(1'b1));
    serve(2, 1'b1, 1'b0);

    // Fixed priority with two requesters.
    bus.dreq = 4'b1010;
    serve(model_winner(4'b1010, 1'b0, last_m), 1'b1, 1'b0);

    // Masked hardware request is ignored; software request is not.
    bus.mask = 4'b0001;
    bus.dreq = 4'b0001;
    repeat (6) tick();
    check("masked_hrq", 32'(bus.hrq), 32'(1'b0));
    bus.sw_req = 4'b0001;
    serve(0, 1'b1, 1'b0);
    bus.mask = 4'b0000;

    // HLDA drop during a grant on ch3 -> single-cycle abort.
    bus.dreq = 4'b1000;
    wait_hrq(1'b1, 12);
    tick();
    tick();
    bus.hlda = 1'b1;
    tick();
    check("ab_gch", 32'(bus.grant_ch), 32'(2'd3));
    check("ab_dack_g", 32'(bus.dack), 32'(4'b0111));
    last_m   = 3;
    bus.dreq = 4'b0000;
    tick();
    tick();
    bus.hlda = 1'b0;
    tick();
    check("ab_pulse", 32'(bus.abort), 32'(1'b1));
    check("ab_dack", 32'(bus.dack), 32'(4'b1111));
    check("ab_hrq", 32'(bus.hrq), 32'(1'b0));
    check("ab_gv", 32'(bus.grant_valid), 32'(1'b0));
    tick();
    check("ab_end", 32'(bus.abort), 32'(1'b0));
    check("ab_idle", 32'(bus.hrq), 32'(1'b0));

    // Rotating priority, all channels requesting, last grant was ch3.
    bus.rot_pri = 1'b1;
    bus.dreq    = 4'b1111;
    serve(0, 1'b0, 1'b0);
    serve(1, 1'b0, 1'b0);
    serve(2, 1'b1, 1'b0);
    bus.rot_pri = 1'b0;

    // Request withdrawn while waiting for HLDA.
    bus.dreq = 4'b0100;
    wait_hrq(1'b1, 12);
    bus.dreq = 4'b0000;
    wait_hrq(1'b0, 6);
    check("wd_dack", 32'(bus.dack), 32'(4'b1111));
    check("wd_gv", 32'(bus.grant_valid), 32'(1'b0));

    // Acknowledge sense is combinational; reset mid-grant clears at once.
    bus.dreq = 4'b0001;
    wait_hrq(1'b1, 12);
    tick();
    tick();
    bus.hlda = 1'b1;
    tick();
    check("rg_gv", 32'(bus.grant_valid), 32'(1'b1));
    bus.dack_sense_high = 1'b1;
    #1;
    check("sense_hi", 32'(bus.dack), 32'(4'b0001));
    bus.dack_sense_high = 1'b0;
    #1;
    check("sense_lo", 32'(bus.dack), 32'(4'b1110));
    rst = 1'b1;
    #1;
    check("rg_hrq", 32'(bus.hrq), 32'(1'b0));
    check("rg_dack", 32'(bus.dack), 32'(4'b1111));
    check("rg_abort", 32'(bus.abort), 32'(1'b0));
    check("rg_gv0", 32'(bus.grant_valid), 32'(1'b0));
    bus.dreq = 4'b0000;
    bus.hlda = 1'b0;
    tick();
    tick();
    rst    = 1'b0;
    last_m = 3;
    tick();
    check("rg_after", 32'(bus.abort), 32'(1'b0));

    // Inverted senses: active-low DREQ, active-high DACK.
    bus.dreq_sense_low  = 1'b1;
    bus.dack_sense_high = 1'b1;
    bus.dreq            = 4'b1110;
    serve(model_winner(4'b0001, 1'b0, last_m), 1'b1, 1'b0);
    bus.dreq_sense_low  = 1'b0;
    bus.dack_sense_high = 1'b0;
    bus.dreq            = 4'b0000;
    tick();
    tick();

    // Randomized requests, masks, modes and endings.
    for (int it = 0; it < 24; it++) begin
      rot         = 1'($urandom_range(0, 1));
      bus.rot_pri = rot;
      bus.mask    = 4'($urandom);
      bus.dreq    = 4'($urandom);
      bus.sw_req  = 4'($urandom) & 4'($urandom);
      eff = (bus.dreq & ~bus.mask) | bus.sw_req;
      if (eff == 4'b0000) begin
        bus.sw_req = 4'b0001 << $urandom_range(0, 3);
        eff        = bus.sw_req;
      end
      serve(model_winner(eff, rot, last_m), 1'b1, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_priority.md
DMA_PRIORITY -- requirements
Module: dma_priority

Interface
REQ-001 CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 RESET  input  1  asynchronous, active-high reset.
REQ-003 DREQ  input  4  asynchronous channel request lines from peripherals.
REQ-004 HLDA  input  1  hold acknowledge from CPU.
REQ-005 HRQ  output  1  hold request to CPU.
REQ-006 DACK  output  4  per-channel acknowledge to peripherals.
REQ-007 dreq_sense_low  input  1  0: DREQ active-high; 1: DREQ active-low (from command register).
REQ-008 dack_sense_high  input  1  0: DACK active-low; 1: DACK active-high (from command register).
REQ-009 rot_pri  input  1  0: fixed priority; 1: rotating priority.
REQ-010 mask  input  4  per-channel mask; 1 blocks hardware DREQ.
REQ-011 sw_req  input  4  software request bits; never masked.
REQ-012 svc_done  input  1  one-cycle pulse from timing control: current service finished (end of block, TC or EOP).
REQ-013 grant_valid  output  1  high while a channel owns the bus.
REQ-014 grant_ch  output  2  granted channel index; valid only when grant_valid=1.
REQ-015 abort  output  1  one-cycle pulse when HLDA drops during a grant.

Function
REQ-016 DREQ is polarity-corrected per dreq_sense_low, then passed through a 2-flop synchronizer; the synchronized value is "hw_req".
REQ-017 eff_req[i] = (hw_req[i] & ~mask[i]) | sw_req[i].
REQ-018 FSM states: IDLE, WAIT_HLDA, GRANT.
REQ-019 IDLE: HRQ=0, DACK inactive; if any eff_req bit is set, go to WAIT_HLDA next cycle.
REQ-020 WAIT_HLDA: HRQ=1; if HLDA=1, latch the winner of eff_req into grant_ch and go to GRANT; if eff_req==0 and HLDA=0, go to IDLE with HRQ=0 the next cycle.
REQ-021 WAIT_HLDA with HLDA=1 and eff_req==0: go to IDLE, no grant.
REQ-022 GRANT: HRQ=1, grant_valid=1, DACK[grant_ch] active, all other DACK bits inactive; grant_ch is held constant regardless of later changes to eff_req, mask or rot_pri.
REQ-023 GRANT + svc_done: go to IDLE next cycle; HRQ, DACK and grant_valid deassert on that edge.
REQ-024 GRANT + HLDA=0 (no svc_done): pulse abort for 1 cycle; go to IDLE; DACK inactive next cycle.
REQ-025 svc_done and HLDA fall in the same cycle: treat as svc_done; no abort.
REQ-026 Fixed priority: channel 0 highest, channel 3 lowest.
REQ-027 Rotating priority: the channel last granted becomes lowest priority, and order proceeds cyclically (last=1 gives 2,3,0,1). The pointer updates on entry to GRANT; its reset value makes ch0 highest.
REQ-028 A change to rot_pri takes effect at the next arbitration; the rotation pointer is not cleared.
REQ-029 Arbitration latency: a DREQ edge produces HRQ=1 no earlier than 3 CLK edges later (2 synchronizer edges plus the FSM edge).
REQ-030 DACK output = active_vector XOR {4{~dack_sense_high}}; a sense change is reflected combinationally.

Reset
REQ-031 While RESET=1: state=IDLE, HRQ=0, grant_valid=0, grant_ch=0, abort=0, synchronizer flops=0, rotation pointer=3 (ch0 highest). DACK is at its inactive level, which is 4'b1111 with dack_sense_high=0.
REQ-032 RESET asserted mid-GRANT drops HRQ and DACK asynchronously and does not pulse abort.

Structure
REQ-033 Shared package dma_pkg holds NUM_CH=4, the channel index typedef, and the state enum {IDLE, WAIT_HLDA, GRANT}.
REQ-034 Sub-module dma_sync2 (a 2-flop synchronizer, width parameter) is instantiated once for the 4-bit DREQ.

Verification
REQ-035 DREQ=4'b0100, mask=0, HLDA raised 2 cycles after HRQ -> HRQ at 3rd edge, DACK=4'b1011, grant_ch=2; svc_done -> DACK=4'b1111, HRQ=0.
REQ-036 Fixed priority, DREQ=4'b1010 -> grant_ch=1; rotating priority with 3 back-to-back services, DREQ=4'b1111 held -> grant order 0,1,2.
REQ-037 mask=4'b0001, DREQ=4'b0001, sw_req=0 -> HRQ stays 0; then sw_req=4'b0001 -> grant_ch=0.
REQ-038 In GRANT on ch3, drop HLDA -> abort=1 for exactly 1 cycle, DACK inactive, FSM in IDLE.
REQ-039 DREQ withdrawn in WAIT_HLDA before HLDA -> HRQ drops, no DACK; RESET asserted mid-GRANT -> HRQ=0 and DACK=4'b1111 immediately.
REQ-040 dreq_sense_low=1, dack_sense_high=1, DREQ=4'b1110 -> grant_ch=0, DACK=4'b0001.
